regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Sits between the writeback sources and the 32x32 register file, which has one write port and two read ports.
- Shares the single write port between two sources:
  - the main pipeline writeback, which has priority and no handshake;
  - a multicycle auxiliary unit (mult/div/load miss), which uses a valid/ready handshake.
- Keeps a busy scoreboard of registers reserved by the aux unit, and flags decode read hazards against it.
- Bounds aux starvation by forcing a pipeline stall after MAX_WAIT lost cycles.

Parameters:
- MAX_WAIT, 4: consecutive cycles an aux request may lose arbitration before it is forced through; legal range 1..15.
- WAIT_WIDTH, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pipe_write_enable  in  1  pipeline WB write request.
- pipe_write_address  in  5  pipeline WB destination.
- pipe_write_data  in  32  pipeline WB data.
- pipe_stall  out  1  pipeline must hold WB contents this cycle; its write is ignored.
- aux_reserve_enable  in  1  decode issued an aux op; reserve its destination.
- aux_reserve_address  in  5  destination being reserved.
- aux_valid  in  1  aux result available.
- aux_address  in  5  aux result destination.
- aux_data  in  32  aux result data.
- aux_ready  out  1  aux result accepted this cycle.
- write_enable  out  1  to register file.
- write_address  out  5  to register file.
- write_data  out  32  to register file.
- read_enable_a  in  1  decode read port A active.
- read_address_a  in  5  decode read port A address.
- read_enable_b  in  1  decode read port B active.
- read_address_b  in  5  decode read port B address.
- hazard_stall  out  1  decode must stall (RAW on a busy register).
- reserve_conflict  out  1  sticky error: a register was reserved while already busy.

Behaviour:
- State: busy[31:0], wait_count[WAIT_WIDTH-1:0], force_aux, reserve_conflict. All are cleared asynchronously on reset.
- Outputs during reset:
  - write_enable=0, aux_ready=0, pipe_stall=0, hazard_stall=0;
  - write_address=0, write_data=0.
- Definitions:
  - pipe_wants = pipe_write_enable && pipe_write_address!=0.
- Grant (combinational, zero latency; the register file writes on the same rising edge):
  - pipe_stall = force_aux.
  - aux_ready = aux_valid && (force_aux || !pipe_wants).
  - If aux_ready: write_enable = (aux_address!=0); write_address/write_data come from aux.
  - Else if pipe_wants && !force_aux: write_enable=1; address/data come from the pipe.
  - Else: write_enable=0; write_address=0; write_data=0.
- Starvation control:
  - wait_count increments when aux_valid && !aux_ready, and saturates at MAX_WAIT.
  - wait_count clears to 0 on aux_ready, or when aux_valid=0.
  - force_aux is set at the edge where wait_count becomes MAX_WAIT. It is therefore asserted exactly after MAX_WAIT lost cycles.
  - While force_aux=1: aux_ready=1 is guaranteed if aux_valid=1.
  - force_aux clears on the next edge, or immediately clears if aux_valid drops.
- Aux handshake: aux must hold valid/address/data stable until aux_ready.
- Scoreboard:
  - On aux_reserve_enable with address!=0: set busy[address] at the edge.
  - On aux_ready with aux_address!=0: clear busy[aux_address].
  - Reserve and clear to the same address in the same cycle: set wins.
  - Reserve of an already-busy register (not being cleared that cycle): busy stays 1 and reserve_conflict is set (sticky until reset).
  - busy[0] is always 0.
- Hazard:
  - hazard_stall = (read_enable_a && read_address_a!=0 && busy[read_address_a] && !(aux_ready && aux_address==read_address_a)) OR the same term for port B.
  - A same-cycle aux write does not stall, because the register file bypasses write_data.
  - A same-cycle reservation does not affect hazard_stall until the next cycle.
- Caller contract: decode must not issue a pipeline write to a busy register. This is not checked.
- Reset mid-operation: busy vector and counters are lost; in-flight aux results after reset are written normally. busy is unaffected because it is already 0.

Decomposition:
- Shared package, regfile_pkg:
  - REG_COUNT=32, REG_ADDR_WIDTH=5, DATA_WIDTH=32, ZERO_REG=5'd0;
  - write-request bundle typedef {enable, address, data}.
- One sub-module, regfile_scoreboard:
  - contains the busy vector, the set/clear/conflict logic and the two hazard comparators;
  - the parent keeps the arbitration and starvation logic.

Test Plan:
- Reset released, idle: busy=0; pipe write r5=0x1234 -> same cycle write_enable=1, write_address=5, write_data=0x1234, pipe_stall=0.
- Aux alone, aux_valid, aux_address=7, data=0xAAAA0001, pipe idle -> aux_ready=1, write_address=7; aux to r0 -> aux_ready=1, write_enable=0.
- Starvation, MAX_WAIT=4, pipe writes every cycle and aux_valid held:
  - aux_ready=0 for 4 cycles;
  - cycle 5: pipe_stall=1, aux_ready=1, write_address=aux_address;
  - cycle 6: pipe_stall=0.
- Scoreboard, reserve r9 then read_address_a=9, read_enable_a=1:
  - next cycle hazard_stall=1;
  - in the cycle aux writes r9, hazard_stall=0;
  - afterwards busy[9]=0.
- Reserve r9 while busy -> reserve_conflict=1 and it stays 1. Reserve r3 in the same cycle as the aux clear of r3 -> busy[3]=1 afterwards.
- Assert reset asynchronously while force_aux=1 and busy=0x00000280 -> immediately all outputs 0, busy=0, wait_count=0, force_aux=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
package regfile_pkg;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  typedef struct packed {
    logic      enable;
    reg_addr_t address;
    reg_data_t data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of pipeline WB, aux handshake, register-file write and decode read signals.
interface regfile_write_scheduler_if;
  import regfile_pkg::*;

  logic      pipe_write_enable;
  reg_addr_t pipe_write_address;
  reg_data_t pipe_write_data;
  logic      pipe_stall;

  logic      aux_reserve_enable;
  reg_addr_t aux_reserve_address;
  logic      aux_valid;
  reg_addr_t aux_address;
  reg_data_t aux_data;
  logic      aux_ready;

  logic      write_enable;
  reg_addr_t write_address;
  reg_data_t write_data;

  logic      read_enable_a;
  reg_addr_t read_address_a;
  logic      read_enable_b;
  reg_addr_t read_address_b;
  logic      hazard_stall;
  logic      reserve_conflict;

  modport slave (
    input  pipe_write_enable, pipe_write_address, pipe_write_data,
    input  aux_reserve_enable, aux_reserve_address,
    input  aux_valid, aux_address, aux_data,
    input  read_enable_a, read_address_a, read_enable_b, read_address_b,
    output pipe_stall, aux_ready,
    output write_enable, write_address, write_data,
    output hazard_stall, reserve_conflict
  );

  modport master (
    output pipe_write_enable, pipe_write_address, pipe_write_data,
    output aux_reserve_enable, aux_reserve_address,
    output aux_valid, aux_address, aux_data,
    output read_enable_a, read_address_a, read_enable_b, read_address_b,
    input  pipe_stall, aux_ready,
    input  write_enable, write_address, write_data,
    input  hazard_stall, reserve_conflict
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for registers reserved by the aux unit, plus decode RAW hazard detection.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reserve_enable,
  input  reg_addr_t            reserve_address,
  input  logic                 clear_enable,
  input  reg_addr_t            clear_address,
  input  logic                 read_enable_a,
  input  reg_addr_t            read_address_a,
  input  logic                 read_enable_b,
  input  reg_addr_t            read_address_b,
  output logic [REG_COUNT-1:0] busy,
  output logic                 hazard_stall,
  output logic                 reserve_conflict
);
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [REG_COUNT-1:0] set_mask, clear_mask;
  logic                 conflict_q, conflict_d;
  logic                 hazard_a, hazard_b;

  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (clear_enable && clear_address != ZERO_REG)
      clear_mask[clear_address] = 1'b1;
    if (reserve_enable && reserve_address != ZERO_REG)
      set_mask[reserve_address] = 1'b1;
    // Set is applied after clear so a same-cycle reserve of the retiring register wins.
    busy_d    = (busy_q & ~clear_mask) | set_mask;
    busy_d[0] = 1'b0;
    conflict_d = conflict_q | (|(set_mask & busy_q & ~clear_mask));

    // A register being written this cycle is bypassed by the register file.
    hazard_a = read_enable_a && (read_address_a != ZERO_REG) && busy_q[read_address_a]
               && !(clear_enable && clear_address == read_address_a);
    hazard_b = read_enable_b && (read_address_b != ZERO_REG) && busy_q[read_address_b]
               && !(clear_enable && clear_address == read_address_b);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy             = busy_q;
  assign hazard_stall     = hazard_a || hazard_b;
  assign reserve_conflict = conflict_q;
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between pipeline WB (priority) and the aux unit,
// forcing an aux grant and a pipeline stall after MAX_WAIT consecutive lost cycles.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT   = 4,
  parameter int WAIT_WIDTH = 4
) (
  input logic                     clock,
  input logic                     reset,
  regfile_write_scheduler_if.slave bus
);
  localparam logic [WAIT_WIDTH-1:0] MAX_WAIT_W = WAIT_WIDTH'(MAX_WAIT);

  logic [WAIT_WIDTH-1:0] wait_count_q, wait_count_d;
  logic                  force_q, force_d;
  logic                  pipe_wants, force_aux, aux_ready, lost;
  wr_req_t               wr;
  logic [REG_COUNT-1:0]  busy;
  logic                  hazard_stall, reserve_conflict;

  always_comb begin
    pipe_wants = bus.pipe_write_enable && (bus.pipe_write_address != ZERO_REG);
    // A dropped aux request releases the forced grant without waiting for the edge.
    force_aux  = force_q && bus.aux_valid;
    aux_ready  = !reset && bus.aux_valid && (force_aux || !pipe_wants);

    wr = '0;
    if (!reset) begin
      if (aux_ready) begin
        wr.enable  = (bus.aux_address != ZERO_REG);
        wr.address = bus.aux_address;
        wr.data    = bus.aux_data;
      end else if (pipe_wants && !force_aux) begin
        wr.enable  = 1'b1;
        wr.address = bus.pipe_write_address;
        wr.data    = bus.pipe_write_data;
      end
    end

    lost = bus.aux_valid && !aux_ready;
    if (lost)
      wait_count_d = (wait_count_q == MAX_WAIT_W) ? MAX_WAIT_W : wait_count_q + 1'b1;
    else
      wait_count_d = '0;
    force_d = lost && (wait_count_d == MAX_WAIT_W) && (wait_count_q != MAX_WAIT_W);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_count_q <= '0;
      force_q      <= 1'b0;
    end else begin
      wait_count_q <= wait_count_d;
      force_q      <= force_d;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clock           (clock),
    .reset           (reset),
    .reserve_enable  (bus.aux_reserve_enable),
    .reserve_address (bus.aux_reserve_address),
    .clear_enable    (aux_ready),
    .clear_address   (bus.aux_address),
    .read_enable_a   (bus.read_enable_a),
    .read_address_a  (bus.read_address_a),
    .read_enable_b   (bus.read_enable_b),
    .read_address_b  (bus.read_address_b),
    .busy            (busy),
    .hazard_stall    (hazard_stall),
    .reserve_conflict(reserve_conflict)
  );

  assign bus.pipe_stall       = force_aux;
  assign bus.aux_ready        = aux_ready;
  assign bus.write_enable     = wr.enable;
  assign bus.write_address    = wr.address;
  assign bus.write_data       = wr.data;
  assign bus.hazard_stall     = hazard_stall;
  assign bus.reserve_conflict = reserve_conflict;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed scenarios plus a randomized run against a lost-cycle / busy-set reference model.
module tb_regfile_write_scheduler;
  localparam int MAX_WAIT = 4;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  regfile_write_scheduler_if bus ();

  regfile_write_scheduler #(.MAX_WAIT(MAX_WAIT), .WAIT_WIDTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.pipe_write_enable   = 1'b0;
    bus.pipe_write_address  = 5'd0;
    bus.pipe_write_data     = 32'd0;
    bus.aux_reserve_enable  = 1'b0;
    bus.aux_reserve_address = 5'd0;
    bus.aux_valid           = 1'b0;
    bus.aux_address         = 5'd0;
    bus.aux_data            = 32'd0;
    bus.read_enable_a       = 1'b0;
    bus.read_address_a      = 5'd0;
    bus.read_enable_b       = 1'b0;
    bus.read_address_b      = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.pipe_write_enable  = 1'b1;
    bus.pipe_write_address = 5'd5;
    bus.pipe_write_data    = 32'h1234;
    bus.aux_valid          = 1'b1;
    bus.aux_address        = 5'd6;
    next_cycle();
    #3;
    checks++; if (bus.write_enable !== 1'b0 || bus.write_address !== 5'd0 || bus.write_data !== 32'd0) begin
      failures++; $display("FAIL reset_write got we=%0b a=%0d d=%h exp 0/0/0", bus.write_enable, bus.write_address, bus.write_data); end
    checks++; if (bus.aux_ready !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.hazard_stall !== 1'b0) begin
      failures++; $display("FAIL reset_ctl got rdy=%0b stall=%0b haz=%0b exp 0", bus.aux_ready, bus.pipe_stall, bus.hazard_stall); end
    checks++; if (dut.busy !== 32'd0 || bus.reserve_conflict !== 1'b0) begin
      failures++; $display("FAIL reset_state got busy=%h conf=%0b exp 0", dut.busy, bus.reserve_conflict); end
    do_reset();
  endtask

  task automatic test_pipe_write();
    idle();
    bus.pipe_write_enable  = 1'b1;
    bus.pipe_write_address = 5'd5;
    bus.pipe_write_data    = 32'h1234;
    #3;
    checks++; if (bus.write_enable !== 1'b1 || bus.write_address !== 5'd5 || bus.write_data !== 32'h1234 || bus.pipe_stall !== 1'b0) begin
      failures++; $display("FAIL pipe_write got we=%0b a=%0d d=%h stall=%0b exp 1/5/1234/0",
                           bus.write_enable, bus.write_address, bus.write_data, bus.pipe_stall); end
    next_cycle();
  endtask

  task automatic test_aux_alone();
    idle();
    bus.aux_valid   = 1'b1;
    bus.aux_address = 5'd7;
    bus.aux_data    = 32'hAAAA0001;
    #3;
    checks++; if (bus.aux_ready !== 1'b1 || bus.write_enable !== 1'b1 || bus.write_address !== 5'd7 || bus.write_data !== 32'hAAAA0001) begin
      failures++; $display("FAIL aux_alone got rdy=%0b we=%0b a=%0d d=%h exp 1/1/7/aaaa0001",
                           bus.aux_ready, bus.write_enable, bus.write_address, bus.write_data); end
    next_cycle();
    bus.aux_address = 5'd0;
    #3;
    checks++; if (bus.aux_ready !== 1'b1 || bus.write_enable !== 1'b0) begin
      failures++; $display("FAIL aux_r0 got rdy=%0b we=%0b exp 1/0", bus.aux_ready, bus.write_enable); end
    next_cycle();
    idle();
  endtask

  task automatic test_starvation();
    do_reset();
    bus.aux_valid   = 1'b1;
    bus.aux_address = 5'd21;
    bus.aux_data    = 32'hBEEF0021;
    bus.pipe_write_enable = 1'b1;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      bus.pipe_write_address = 5'(10 + i);
      bus.pipe_write_data    = 32'(i);
      #3;
      checks++; if (bus.aux_ready !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.write_address !== 5'(10 + i)) begin
        failures++; $display("FAIL starve_lost%0d got rdy=%0b stall=%0b a=%0d exp 0/0/%0d",
                             i, bus.aux_ready, bus.pipe_stall, bus.write_address, 10 + i); end
      next_cycle();
    end
    bus.pipe_write_address = 5'd30;
    #3;
    checks++; if (bus.pipe_stall !== 1'b1 || bus.aux_ready !== 1'b1 || bus.write_address !== 5'd21 || bus.write_data !== 32'hBEEF0021) begin
      failures++; $display("FAIL starve_forced got stall=%0b rdy=%0b a=%0d d=%h exp 1/1/21/beef0021",
                           bus.pipe_stall, bus.aux_ready, bus.write_address, bus.write_data); end
    next_cycle();
    bus.aux_valid = 1'b0;
    #3;
    checks++; if (bus.pipe_stall !== 1'b0 || bus.write_enable !== 1'b1 || bus.write_address !== 5'd30) begin
      failures++; $display("FAIL starve_after got stall=%0b we=%0b a=%0d exp 0/1/30", bus.pipe_stall, bus.write_enable, bus.write_address); end
    next_cycle();
    idle();
  endtask

  task automatic test_scoreboard();
    do_reset();
    bus.aux_reserve_enable  = 1'b1;
    bus.aux_reserve_address = 5'd9;
    bus.read_enable_a       = 1'b1;
    bus.read_address_a      = 5'd9;
    #3;
    checks++; if (bus.hazard_stall !== 1'b0) begin
      failures++; $display("FAIL sb_same_cycle_reserve got haz=%0b exp 0", bus.hazard_stall); end
    next_cycle();
    bus.aux_reserve_enable = 1'b0;
    #3;
    checks++; if (bus.hazard_stall !== 1'b1) begin
      failures++; $display("FAIL sb_hazard_a got haz=%0b exp 1", bus.hazard_stall); end
    bus.read_enable_a  = 1'b0;
    bus.read_enable_b  = 1'b1;
    bus.read_address_b = 5'd9;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin
      failures++; $display("FAIL sb_hazard_b got haz=%0b exp 1", bus.hazard_stall); end
    next_cycle();
    bus.read_enable_a = 1'b1;
    bus.aux_valid     = 1'b1;
    bus.aux_address   = 5'd9;
    bus.aux_data      = 32'h99;
    #3;
    checks++; if (bus.hazard_stall !== 1'b0 || bus.aux_ready !== 1'b1 || bus.write_address !== 5'd9) begin
      failures++; $display("FAIL sb_bypass got haz=%0b rdy=%0b a=%0d exp 0/1/9", bus.hazard_stall, bus.aux_ready, bus.write_address); end
    next_cycle();
    bus.aux_valid = 1'b0;
    #3;
    checks++; if (bus.hazard_stall !== 1'b0 || dut.busy[9] !== 1'b0) begin
      failures++; $display("FAIL sb_cleared got haz=%0b busy9=%0b exp 0/0", bus.hazard_stall, dut.busy[9]); end
    next_cycle();
    idle();
  endtask

  task automatic test_conflict();
    do_reset();
    bus.aux_reserve_enable  = 1'b1;
    bus.aux_reserve_address = 5'd9;
    next_cycle();
    #3;
    checks++; if (bus.reserve_conflict !== 1'b0) begin
      failures++; $display("FAIL conf_first got conf=%0b exp 0", bus.reserve_conflict); end
    next_cycle();
    bus.aux_reserve_enable = 1'b0;
    #3;
    checks++; if (bus.reserve_conflict !== 1'b1) begin
      failures++; $display("FAIL conf_set got conf=%0b exp 1", bus.reserve_conflict); end
    next_cycle();
    bus.aux_reserve_enable  = 1'b1;
    bus.aux_reserve_address = 5'd3;
    next_cycle();
    bus.aux_valid   = 1'b1;
    bus.aux_address = 5'd3;
    #3;
    checks++; if (bus.aux_ready !== 1'b1) begin
      failures++; $display("FAIL conf_clear_ready got rdy=%0b exp 1", bus.aux_ready); end
    next_cycle();
    idle();
    bus.read_enable_a  = 1'b1;
    bus.read_address_a = 5'd3;
    #3;
    checks++; if (dut.busy[3] !== 1'b1 || bus.hazard_stall !== 1'b1) begin
      failures++; $display("FAIL set_wins got busy3=%0b haz=%0b exp 1/1", dut.busy[3], bus.hazard_stall); end
    checks++; if (bus.reserve_conflict !== 1'b1 || dut.busy[9] !== 1'b1) begin
      failures++; $display("FAIL conf_sticky got conf=%0b busy9=%0b exp 1/1", bus.reserve_conflict, dut.busy[9]); end
    next_cycle();
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.aux_reserve_enable  = 1'b1;
    bus.aux_reserve_address = 5'd7;
    next_cycle();
    bus.aux_reserve_address = 5'd9;
    next_cycle();
    bus.aux_reserve_enable = 1'b0;
    bus.aux_valid          = 1'b1;
    bus.aux_address        = 5'd12;
    bus.aux_data           = 32'hC0DE0012;
    bus.pipe_write_enable  = 1'b1;
    bus.pipe_write_address = 5'd4;
    for (int i = 0; i < MAX_WAIT; i++) next_cycle();
    #1;
    checks++; if (bus.pipe_stall !== 1'b1 || dut.busy !== 32'h0000_0280) begin
      failures++; $display("FAIL arst_setup got stall=%0b busy=%h exp 1/00000280", bus.pipe_stall, dut.busy); end
    reset = 1'b1;
    #1;
    checks++; if (bus.write_enable !== 1'b0 || bus.aux_ready !== 1'b0 || bus.pipe_stall !== 1'b0 ||
                  bus.hazard_stall !== 1'b0 || bus.write_address !== 5'd0 || bus.write_data !== 32'd0) begin
      failures++; $display("FAIL arst_outputs got we=%0b rdy=%0b stall=%0b haz=%0b a=%0d d=%h exp all 0",
                           bus.write_enable, bus.aux_ready, bus.pipe_stall, bus.hazard_stall, bus.write_address, bus.write_data); end
    checks++; if (dut.busy !== 32'd0 || dut.wait_count_q !== 4'd0 || dut.force_q !== 1'b0) begin
      failures++; $display("FAIL arst_state got busy=%h wc=%0d force=%0b exp 0", dut.busy, dut.wait_count_q, dut.force_q); end
    next_cycle();
    reset = 1'b0;
    bus.pipe_write_enable = 1'b0;
    #3;
    checks++; if (bus.aux_ready !== 1'b1 || bus.write_enable !== 1'b1 || bus.write_address !== 5'd12 || bus.write_data !== 32'hC0DE0012) begin
      failures++; $display("FAIL arst_inflight got rdy=%0b we=%0b a=%0d d=%h exp 1/1/12/c0de0012",
                           bus.aux_ready, bus.write_enable, bus.write_address, bus.write_data); end
    next_cycle();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] mbusy;
    logic        mconf, pend, pw, forced, er, ewe, eh;
    logic [4:0]  aa, ewa, pa, ra, rda, rdb;
    logic [31:0] ad, ewd, pd;
    int          streak;
    do_reset();
    mbusy = '0; mconf = 1'b0; pend = 1'b0; streak = 0; aa = '0; ad = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        aa   = 5'($urandom_range(0, 31));
        ad   = $urandom;
      end
      pa  = 5'($urandom_range(0, 31));
      pd  = $urandom;
      ra  = 5'($urandom_range(0, 31));
      rda = 5'($urandom_range(0, 31));
      rdb = 5'($urandom_range(0, 31));
      bus.aux_valid           = pend;
      bus.aux_address         = aa;
      bus.aux_data            = ad;
      bus.pipe_write_enable   = ($urandom_range(0, 3) != 0);
      bus.pipe_write_address  = pa;
      bus.pipe_write_data     = pd;
      bus.aux_reserve_enable  = ($urandom_range(0, 3) == 0);
      bus.aux_reserve_address = ra;
      bus.read_enable_a       = $urandom_range(0, 1) == 1;
      bus.read_address_a      = rda;
      bus.read_enable_b       = $urandom_range(0, 1) == 1;
      bus.read_address_b      = rdb;
      #3;
      pw     = bus.pipe_write_enable && pa != 0;
      forced = pend && streak >= MAX_WAIT;
      er     = pend && (forced || !pw);
      if (er) begin ewe = (aa != 0); ewa = aa; ewd = ad; end
      else if (pw) begin ewe = 1'b1; ewa = pa; ewd = pd; end
      else begin ewe = 1'b0; ewa = 5'd0; ewd = 32'd0; end
      eh = (bus.read_enable_a && rda != 0 && mbusy[rda] && !(er && aa == rda)) ||
           (bus.read_enable_b && rdb != 0 && mbusy[rdb] && !(er && aa == rdb));
      checks++; if (bus.aux_ready !== er) begin
        failures++; $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, bus.aux_ready, er); end
      checks++; if (bus.pipe_stall !== forced) begin
        failures++; $display("FAIL rnd_stall c=%0d got %0b exp %0b", c, bus.pipe_stall, forced); end
      checks++; if (bus.write_enable !== ewe || bus.write_address !== ewa || bus.write_data !== ewd) begin
        failures++; $display("FAIL rnd_write c=%0d got %0b/%0d/%h exp %0b/%0d/%h", c,
                             bus.write_enable, bus.write_address, bus.write_data, ewe, ewa, ewd); end
      checks++; if (bus.hazard_stall !== eh) begin
        failures++; $display("FAIL rnd_hazard c=%0d got %0b exp %0b", c, bus.hazard_stall, eh); end
      checks++; if (bus.reserve_conflict !== mconf) begin
        failures++; $display("FAIL rnd_conflict c=%0d got %0b exp %0b", c, bus.reserve_conflict, mconf); end
      if (bus.aux_reserve_enable && ra != 0 && mbusy[ra] && !(er && aa == ra)) mconf = 1'b1;
      if (er && aa != 0) mbusy[aa] = 1'b0;
      if (bus.aux_reserve_enable && ra != 0) mbusy[ra] = 1'b1;
      streak = (pend && !er) ? streak + 1 : 0;
      if (er) pend = 1'b0;
      next_cycle();
    end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_pipe_write();
    test_aux_alone();
    test_starvation();
    test_scoreboard();
    test_conflict();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
